// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined add/sub/addc/subb built from 4-bit carry-lookahead groups,
// one WIDTH/STAGES-bit segment per stage with registered inter-segment carries.
module pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);
  localparam int G = WIDTH / STAGES;
  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [3:0] g, p;
    logic [4:0] cc;
    g     = a & b;
    p     = a ^ b;
    cc[0] = c;
    cc[1] = g[0] | (p[0] & c);
    cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c);
    return {cc[4], p ^ cc[3:0]};
  endfunction
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    localparam int R = WIDTH - k * G;
    localparam int P = (k + 1) * G;
    logic         w_v, w_c, w_co;
    logic [R-1:0] w_a, w_b;
    logic [G-1:0] w_seg;
    logic [P-1:0] w_raw, w_ns, r_s;
    logic         r_v, r_c;
    if (k == 0) begin : g_in
      // op is folded into B' and the carry-in here, so it need not travel further
      assign w_v   = in_valid;
      assign w_a   = A;
      assign w_b   = op[0] ? ~B : B;
      assign w_c   = op[1] ? Cin ^ op[0] : op[0];
      assign w_raw = w_seg;
    end else begin : g_mid
      assign w_v   = g_st[k-1].r_v;
      assign w_a   = g_st[k-1].g_op.r_a;
      assign w_b   = g_st[k-1].g_op.r_b;
      assign w_c   = g_st[k-1].r_c;
      assign w_raw = {w_seg, g_st[k-1].r_s};
    end
    always_comb begin
      logic c;
      c     = w_c;
      w_seg = '0;
      for (int j = 0; j < G / 4; j++) {c, w_seg[4*j+:4]} = cla4(w_a[4*j+:4], w_b[4*j+:4], c);
      w_co  = c;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_v;
        r_c <= w_co;
        r_s <= w_ns;
      end
    end
    if (k < STAGES - 1) begin : g_op
      logic [R-G-1:0] r_a, r_b;
      assign w_ns = w_raw;
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a <= w_a[R-1:G];
          r_b <= w_b[R-1:G];
        end
      end
    end else begin : g_fin
      logic w_ovf, r_o;
      assign w_ovf = (w_a[G-1] == w_b[G-1]) && (w_seg[G-1] != w_a[G-1]);
      assign w_ns  = (SAT != 0 && w_ovf) ? {w_a[G-1], {(P-1){~w_a[G-1]}}} : w_raw;
      always_ff @(posedge clk) begin
        if (!rst_n) r_o <= 1'b0;
        else if (w_adv) r_o <= w_ovf;
      end
    end
  end
  assign out_valid = g_st[STAGES-1].r_v;
  assign Sum       = g_st[STAGES-1].r_s;
  assign Cout      = g_st[STAGES-1].r_c;
  assign Ovf       = g_st[STAGES-1].g_fin.r_o;
  assign Zero      = out_valid && Sum == '0;
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: four pipe_addsub configurations on shared stimulus, each checked
// against a plain-arithmetic reference model through its own scoreboard.
module tb_pipe_addsub;
  logic        clk, rst_n, in_valid, out_ready, cin;
  logic [63:0] a, b;
  logic [1:0]  op;
  logic        ov[4], rd[4], co[4], of[4], zr[4];
  logic [15:0] s0, s1;
  logic [31:0] s2;
  logic [7:0]  s3;
  logic [63:0] sm[4];
  int          wd[4] = '{16, 16, 32, 8};
  bit          sv[4] = '{0, 1, 0, 0};
  logic [65:0] sb[4][16];
  int          wp[4], rp[4];
  logic        pst[4];
  int          n_chk = 0, n_fail = 0;

  assign sm[0] = 64'(s0);
  assign sm[1] = 64'(s1);
  assign sm[2] = 64'(s2);
  assign sm[3] = 64'(s3);

  pipe_addsub #(.WIDTH(16), .STAGES(2), .SAT(0)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(rd[0]), .A(a[15:0]), .B(b[15:0]), .op(op), .Cin(cin), .out_valid(ov[0]),
    .out_ready(out_ready), .Sum(s0), .Cout(co[0]), .Ovf(of[0]), .Zero(zr[0]));
  pipe_addsub #(.WIDTH(16), .STAGES(2), .SAT(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(rd[1]), .A(a[15:0]), .B(b[15:0]), .op(op), .Cin(cin), .out_valid(ov[1]),
    .out_ready(out_ready), .Sum(s1), .Cout(co[1]), .Ovf(of[1]), .Zero(zr[1]));
  pipe_addsub #(.WIDTH(32), .STAGES(4), .SAT(0)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(rd[2]), .A(a[31:0]), .B(b[31:0]), .op(op), .Cin(cin), .out_valid(ov[2]),
    .out_ready(out_ready), .Sum(s2), .Cout(co[2]), .Ovf(of[2]), .Zero(zr[2]));
  pipe_addsub #(.WIDTH(8), .STAGES(1), .SAT(0)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(rd[3]), .A(a[7:0]), .B(b[7:0]), .op(op), .Cin(cin), .out_valid(ov[3]),
    .out_ready(out_ready), .Sum(s3), .Cout(co[3]), .Ovf(of[3]), .Zero(zr[3]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // returns {cout, ovf, sum}
  function automatic logic [65:0] ref_op(input int w, input bit sat, input logic [63:0] ra,
                                         input logic [63:0] rb, input logic [1:0] o, input logic c);
    logic [63:0] m, am, bp, s;
    logic [64:0] f;
    logic        c0, v, cy;
    m  = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    am = ra & m;
    bp = o[0] ? (~rb & m) : (rb & m);
    case (o)
      2'd0:    c0 = 1'b0;
      2'd1:    c0 = 1'b1;
      2'd2:    c0 = c;
      default: c0 = !c;
    endcase
    f  = {1'b0, am} + {1'b0, bp} + 65'(c0);
    s  = f[63:0] & m;
    cy = f[w];
    v  = (am[w-1] == bp[w-1]) && (s[w-1] != am[w-1]);
    if (sat && v) s = am[w-1] ? (64'd1 << (w - 1)) : (m >> 1);
    return {cy, v, s};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        wp[i]  <= 0;
        rp[i]  <= 0;
        pst[i] <= 1'b0;
      end else begin
        chk($sformatf("u%0d_in_ready", i), 64'(rd[i]), 64'(!ov[i] || out_ready));
        if (pst[i]) chk($sformatf("u%0d_hold_valid", i), 64'(ov[i]), 64'd1);
        if (ov[i]) begin
          chk($sformatf("u%0d_result_expected", i), 64'(rp[i] != wp[i]), 64'd1);
          if (rp[i] != wp[i]) begin
            chk($sformatf("u%0d_sum", i), sm[i], sb[i][rp[i]%16][63:0]);
            chk($sformatf("u%0d_ovf", i), 64'(of[i]), 64'(sb[i][rp[i]%16][64]));
            chk($sformatf("u%0d_cout", i), 64'(co[i]), 64'(sb[i][rp[i]%16][65]));
            chk($sformatf("u%0d_zero", i), 64'(zr[i]), 64'(sb[i][rp[i]%16][63:0] == 64'd0));
            if (out_ready) rp[i] <= rp[i] + 1;
          end
        end
        if (in_valid && rd[i]) begin
          sb[i][wp[i]%16] <= ref_op(wd[i], sv[i], a, b, op, cin);
          wp[i] <= wp[i] + 1;
        end
        pst[i] <= ov[i] && !out_ready;
      end
    end
  end

  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb, input logic [1:0] top,
                        input logic tc, output int lat);
    @(posedge clk);
    #1;
    a = ta; b = tb; op = top; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!ov[0] && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          lat, k, n;
    logic [15:0] got[8];
    int          cyc[8];
    clk = 0; rst_n = 0; in_valid = 0; out_ready = 0; a = '0; b = '0; op = '0; cin = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_rst_valid", i), 64'(ov[i]), 64'd0);
      chk($sformatf("u%0d_rst_sum", i), sm[i], 64'd0);
      chk($sformatf("u%0d_rst_cout", i), 64'(co[i]), 64'd0);
      chk($sformatf("u%0d_rst_ovf", i), 64'(of[i]), 64'd0);
      chk($sformatf("u%0d_rst_zero", i), 64'(zr[i]), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("u%0d_ready_after_rst", i), 64'(rd[i]), 64'd1);

    chk("model_add", 64'(ref_op(16, 0, 64'hFFFF, 64'h1, 2'd0, 1'b0)), 64'({2'b10, 64'h0}));
    chk("model_sub", 64'(ref_op(16, 0, 64'h8000, 64'h1, 2'd1, 1'b0)), 64'({2'b11, 64'h7FFF}));
    chk("model_sub_sat", 64'(ref_op(16, 1, 64'h8000, 64'h1, 2'd1, 1'b0)), 64'({2'b11, 64'h8000}));
    chk("model_subb", 64'(ref_op(16, 0, 64'h5, 64'h5, 2'd3, 1'b1)), 64'({2'b00, 64'hFFFF}));

    run_op(64'hFFFF, 64'h0001, 2'd0, 1'b0, lat);
    chk("add_latency", 64'(lat), 64'd2);
    chk("add_sum", 64'(s0), 64'h0000);
    chk("add_cout", 64'(co[0]), 64'd1);
    chk("add_ovf", 64'(of[0]), 64'd0);
    chk("add_zero", 64'(zr[0]), 64'd1);
    run_op(64'h8000, 64'h0001, 2'd1, 1'b0, lat);
    chk("sub_sum", 64'(s0), 64'h7FFF);
    chk("sub_cout", 64'(co[0]), 64'd1);
    chk("sub_ovf", 64'(of[0]), 64'd1);
    chk("sub_zero", 64'(zr[0]), 64'd0);
    chk("sub_sat_sum", 64'(s1), 64'h8000);
    chk("sub_sat_ovf", 64'(of[1]), 64'd1);
    run_op(64'h00FF, 64'h0F00, 2'd2, 1'b1, lat);
    chk("addc_sum", 64'(s0), 64'h1000);
    chk("addc_cout", 64'(co[0]), 64'd0);
    chk("addc_ovf", 64'(of[0]), 64'd0);
    run_op(64'h0005, 64'h0005, 2'd3, 1'b1, lat);
    chk("subb_sum", 64'(s0), 64'hFFFF);
    chk("subb_cout", 64'(co[0]), 64'd0);

    // backpressure: four ADDs 0x1000*(k+1) + 0x0234 offered with the consumer stalled
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b1; op = 2'd0; cin = 1'b0; b = 64'h0234; k = 0;
    for (int t = 0; t < 6; t++) begin
      a = 64'h1000 * (k + 1);
      @(negedge clk);
      if (rd[0]) k++;
      @(posedge clk);
      #1;
    end
    a = 64'h1000 * (k + 1);
    chk("bp_accepted", 64'(k), 64'd2);
    @(negedge clk);
    chk("bp_in_ready", 64'(rd[0]), 64'd0);
    chk("bp_held_valid", 64'(ov[0]), 64'd1);
    chk("bp_held_sum", 64'(s0), 64'h1234);
    @(posedge clk);
    #1 out_ready = 1'b1;
    n = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (ov[0] && n < 8) begin
        got[n] = s0;
        cyc[n] = t;
        n++;
      end
      if (in_valid && rd[0]) k++;
      @(posedge clk);
      #1;
      in_valid = k < 4;
      a = 64'h1000 * (k + 1);
    end
    chk("bp_drained", 64'(n), 64'd4);
    for (int j = 0; j < 4; j++) chk($sformatf("bp_order%0d", j), 64'(got[j]), 64'h1234 + 64'h1000 * j);
    chk("bp_one_per_cycle", 64'(cyc[3] - cyc[0]), 64'd3);

    // reset with operations in flight
    out_ready = 1'b0; in_valid = 1'b1; a = 64'h1111; b = 64'h2222; op = 2'd0;
    @(posedge clk);
    #1 a = 64'h3333;
    @(posedge clk);
    #1;
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_midrst_valid", i), 64'(ov[i]), 64'd0);
      chk($sformatf("u%0d_midrst_sum", i), sm[i], 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("u%0d_no_stale", i), 64'(ov[i]), 64'd0);
    end

    // randomized traffic; every accepted set is scored by the checker process
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      #1;
      in_valid  = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      op  = 2'($urandom_range(0, 3));
      cin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 64'h8000_0000_8000_0080;
      if ($urandom_range(0, 7) == 0) b = 64'h7FFF_FFFF_7FFF_FF7F;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("u%0d_all_drained", i), 64'(wp[i] - rp[i]), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
